// File: rtl/flash_cycle_pkg.sv
// Shared types and constants for the Flash bus-cycle controller.
package flash_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    ACK,
    RECOVER
  } cycleState_t;

  localparam int unsigned RD_WAIT_DEF     = 1;
  localparam int unsigned WR_WAIT_DEF     = 2;
  localparam int unsigned WR_RECOVERY_DEF = 1;

  localparam logic [1:0] STB_IDLE = 2'b11;

  // The timer's zero flag ends a phase on the edge that would decrement it to
  // zero, so a phase of N cycles loads N-1. Zero and one both give one cycle.
  function automatic int unsigned waitLoad(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/flash_wait_timer.sv
// Loadable down-counter with zero flag. STROBE and RECOVER share one instance.
module flash_wait_timer #(
  parameter int unsigned WAIT_W = 3
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              load,
  input  logic              enable,
  input  logic [WAIT_W-1:0] loadValue,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_bus_cycle_ctrl.sv
// Turns a decoded 68000 Flash access into timed strobes and DTACK_n.
// Optional write lock (unlock pulse required before each write burst): FLASH_WR_LOCK_EN.
module flash_bus_cycle_ctrl
  import flash_cycle_pkg::*;
#(
  parameter int unsigned RD_WAIT     = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT     = WR_WAIT_DEF,
  parameter int unsigned WR_RECOVERY = WR_RECOVERY_DEF,
  parameter int unsigned WAIT_W      = 3
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       CPU_AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ACCESS_REQ,
  input  logic       WRITE_ALLOWED,
  input  logic       UNLOCK_REQ,
  output logic [1:0] FLASH_RD_n,
  output logic [1:0] FLASH_WR_n,
  output logic       DTACK_n,
  output logic       WR_BLOCKED
);

  localparam logic [WAIT_W-1:0] RD_LOAD  = WAIT_W'(waitLoad(RD_WAIT));
  localparam logic [WAIT_W-1:0] WR_LOAD  = WAIT_W'(waitLoad(WR_WAIT));
  localparam logic [WAIT_W-1:0] REC_LOAD = WAIT_W'(waitLoad(WR_RECOVERY));

  cycleState_t       state, stateNext;
  logic              as, ds, startReq, writeGate, wrActive;
  logic [1:0]        rdStb, rdStbNext, wrStb, wrStbNext;
  logic              dtackLow, dtackLowNext, wrBlocked, wrBlockedNext;
  logic              timerLoad, timerEnable, timerZero;
  logic [WAIT_W-1:0] timerValue;

  assign as       = !CPU_AS_n;
  assign ds       = !UDS_n || !LDS_n;
  assign startReq = as && ds && ACCESS_REQ;
  // A started cycle always has at least one DS low, so any non-idle write strobe means a real write.
  assign wrActive = (wrStb != STB_IDLE);

`ifdef FLASH_WR_LOCK_EN
  logic isRead, wrUnlocked;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      isRead     <= 1'b0;
      wrUnlocked <= 1'b0;
    end else begin
      if (state == IDLE && startReq) isRead <= RW;
      if (UNLOCK_REQ) begin
        wrUnlocked <= 1'b1;
      end else if (state == ACK && !as && isRead) begin
        wrUnlocked <= 1'b0;
      end
    end
  end

  assign writeGate = WRITE_ALLOWED && wrUnlocked;
`else
  wire unusedUnlock = UNLOCK_REQ;
  assign writeGate = WRITE_ALLOWED;
`endif

  flash_wait_timer #(.WAIT_W(WAIT_W)) waitTimer (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .load      (timerLoad),
    .enable    (timerEnable),
    .loadValue (timerValue),
    .zero      (timerZero)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext     = state;
    rdStbNext     = rdStb;
    wrStbNext     = wrStb;
    dtackLowNext  = dtackLow;
    wrBlockedNext = 1'b0;
    timerLoad     = 1'b0;
    timerEnable   = 1'b0;
    timerValue    = '0;
    unique case (state)
      IDLE: begin
        if (startReq) begin
          stateNext = STROBE;
          timerLoad = 1'b1;
          if (RW) begin
            timerValue = RD_LOAD;
            rdStbNext  = {UDS_n, LDS_n};
          end else begin
            timerValue = WR_LOAD;
            if (writeGate) wrStbNext = {UDS_n, LDS_n};
            else           wrBlockedNext = 1'b1;
          end
        end
      end
      STROBE: begin
        timerEnable = 1'b1;
        if (!as) begin
          rdStbNext = STB_IDLE;
          wrStbNext = STB_IDLE;
          if (wrActive) begin
            stateNext  = RECOVER;
            timerLoad  = 1'b1;
            timerValue = REC_LOAD;
          end else begin
            stateNext = IDLE;
          end
        end else if (timerZero) begin
          stateNext    = ACK;
          dtackLowNext = 1'b1;
        end
      end
      ACK: begin
        if (!as) begin
          rdStbNext    = STB_IDLE;
          wrStbNext    = STB_IDLE;
          dtackLowNext = 1'b0;
          if (wrActive && (WR_RECOVERY != 0)) begin
            stateNext  = RECOVER;
            timerLoad  = 1'b1;
            timerValue = REC_LOAD;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      RECOVER: begin
        timerEnable = 1'b1;
        if (timerZero) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      rdStb     <= STB_IDLE;
      wrStb     <= STB_IDLE;
      dtackLow  <= 1'b0;
      wrBlocked <= 1'b0;
    end else begin
      state     <= stateNext;
      rdStb     <= rdStbNext;
      wrStb     <= wrStbNext;
      dtackLow  <= dtackLowNext;
      wrBlocked <= wrBlockedNext;
    end
  end

  assign FLASH_RD_n = rdStb;
  assign FLASH_WR_n = wrStb;
  assign WR_BLOCKED = wrBlocked;
  assign DTACK_n    = dtackLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_flash_bus_cycle_ctrl.sv
// Directed bench for flash_bus_cycle_ctrl; expected cycles are queued at drive time.
module tb_flash_bus_cycle_ctrl;

  localparam int unsigned RD_WAIT     = 1;
  localparam int unsigned WR_WAIT     = 2;
  localparam int unsigned WR_RECOVERY = 1;
`ifdef FLASH_WR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b1;
  logic       CPU_AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1;
  logic       ACCESS_REQ = 1'b0, WRITE_ALLOWED = 1'b0, UNLOCK_REQ = 1'b0;
  logic [1:0] FLASH_RD_n, FLASH_WR_n;
  logic       WR_BLOCKED;
  wire        DTACK_n;

  // Bus pull-up: a released DTACK_n reads as 1.
  pullup (DTACK_n);

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic       blk;
    int         edges;
    logic       isRead;
  } expCycle_t;

  expCycle_t sbQ[$];
  expCycle_t cur;
  int        testsRun = 0;
  int        testsFailed = 0;
  bit        tbUnlocked = 1'b0;

  always #5 CLK = ~CLK;

  flash_bus_cycle_ctrl #(
    .RD_WAIT     (RD_WAIT),
    .WR_WAIT     (WR_WAIT),
    .WR_RECOVERY (WR_RECOVERY),
    .WAIT_W      (3)
  ) dut (
    .CLK           (CLK),
    .RESET_n       (RESET_n),
    .CPU_AS_n      (CPU_AS_n),
    .UDS_n         (UDS_n),
    .LDS_n         (LDS_n),
    .RW            (RW),
    .ACCESS_REQ    (ACCESS_REQ),
    .WRITE_ALLOWED (WRITE_ALLOWED),
    .UNLOCK_REQ    (UNLOCK_REQ),
    .FLASH_RD_n    (FLASH_RD_n),
    .FLASH_WR_n    (FLASH_WR_n),
    .DTACK_n       (DTACK_n),
    .WR_BLOCKED    (WR_BLOCKED)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait 0 still acknowledges one edge after the strobe.
  function automatic int edgesFor(input int unsigned w);
    return (w == 0) ? 1 : int'(w);
  endfunction

  task automatic idleBus();
    CPU_AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; ACCESS_REQ = 1'b0;
  endtask

  task automatic pulseUnlock();
    UNLOCK_REQ = 1'b1;
    tick();
    UNLOCK_REQ = 1'b0;
    tbUnlocked = 1'b1;
  endtask

  task automatic startCycle(input logic rw, input logic uds, input logic lds, input logic allowed);
    expCycle_t e;
    bit        strobe;
    CPU_AS_n = 1'b0; UDS_n = uds; LDS_n = lds; RW = rw;
    ACCESS_REQ = 1'b1; WRITE_ALLOWED = allowed;
    strobe   = rw || (allowed && (!LOCK_EN || tbUnlocked));
    e.rd     = rw ? {uds, lds} : 2'b11;
    e.wr     = (!rw && strobe) ? {uds, lds} : 2'b11;
    e.blk    = !strobe;
    e.edges  = edgesFor(rw ? RD_WAIT : WR_WAIT);
    e.isRead = rw;
    sbQ.push_back(e);
  endtask

  // Strobes appear on the edge that samples the start; then disturb DS/ACCESS_REQ.
  task automatic firstEdge(input string tag);
    tick();
    cur = sbQ.pop_front();
    check({tag, "_rd"}, {6'd0, FLASH_RD_n}, {6'd0, cur.rd});
    check({tag, "_wr"}, {6'd0, FLASH_WR_n}, {6'd0, cur.wr});
    check({tag, "_blk"}, {7'd0, WR_BLOCKED}, {7'd0, cur.blk});
    check({tag, "_dtack_off"}, {7'd0, DTACK_n}, 8'd1);
    UDS_n = 1'b0; LDS_n = 1'b0; ACCESS_REQ = 1'b0; WRITE_ALLOWED = ~WRITE_ALLOWED;
  endtask

  task automatic waitAck(input string tag);
    int n = 0;
    while (DTACK_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 8'(n), 8'(cur.edges));
    check({tag, "_ack_rd"}, {6'd0, FLASH_RD_n}, {6'd0, cur.rd});
    check({tag, "_ack_wr"}, {6'd0, FLASH_WR_n}, {6'd0, cur.wr});
  endtask

  task automatic releaseCycle(input string tag);
    tick();
    check({tag, "_hold_dtack"}, {7'd0, DTACK_n}, 8'd0);
    check({tag, "_hold_blk"}, {7'd0, WR_BLOCKED}, 8'd0);
    idleBus();
    tick();
    check({tag, "_rel_rd"}, {6'd0, FLASH_RD_n}, 8'h03);
    check({tag, "_rel_wr"}, {6'd0, FLASH_WR_n}, 8'h03);
    check({tag, "_rel_dtack"}, {7'd0, DTACK_n}, 8'd1);
    if (cur.isRead) tbUnlocked = 1'b0;
  endtask

  task automatic fullCycle(input string tag, input logic rw, input logic uds, input logic lds,
                           input logic allowed);
    startCycle(rw, uds, lds, allowed);
    firstEdge(tag);
    waitAck(tag);
    releaseCycle(tag);
  endtask

  initial begin
    #1 RESET_n = 1'b0;
    #1;
    check("rst_rd", {6'd0, FLASH_RD_n}, 8'h03);
    check("rst_wr", {6'd0, FLASH_WR_n}, 8'h03);
    check("rst_dtack", {7'd0, DTACK_n}, 8'd1);
    check("rst_blk", {7'd0, WR_BLOCKED}, 8'd0);
    #10 RESET_n = 1'b1;
    tick();

    fullCycle("rd_word", 1'b1, 1'b0, 1'b0, 1'b0);
    fullCycle("rd_lower", 1'b1, 1'b1, 1'b0, 1'b0);

    // Strobes present but the decoder does not claim the address.
    CPU_AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; ACCESS_REQ = 1'b0;
    tick();
    tick();
    check("noreq_rd", {6'd0, FLASH_RD_n}, 8'h03);
    check("noreq_wr", {6'd0, FLASH_WR_n}, 8'h03);
    check("noreq_dtack", {7'd0, DTACK_n}, 8'd1);
    idleBus();
    tick();

    // Upper-byte write, then a read held pending through recovery.
    pulseUnlock();
    fullCycle("wr_upper", 1'b0, 1'b0, 1'b1, 1'b1);
    startCycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < edgesFor(WR_RECOVERY); i++) begin
      tick();
      check("recover_hold", {6'd0, FLASH_RD_n}, 8'h03);
    end
    firstEdge("rd_after_wr");
    waitAck("rd_after_wr");
    releaseCycle("rd_after_wr");

    // Write to a non-writable window, then an immediate read (no recovery).
    fullCycle("wr_blocked", 1'b0, 1'b0, 1'b0, 1'b0);
    fullCycle("rd_after_blk", 1'b1, 1'b0, 1'b1, 1'b0);

    // Aborted read returns straight to IDLE.
    startCycle(1'b1, 1'b0, 1'b0, 1'b0);
    firstEdge("ab_rd");
    idleBus();
    tick();
    check("ab_rd_rel", {6'd0, FLASH_RD_n}, 8'h03);
    check("ab_rd_dtack", {7'd0, DTACK_n}, 8'd1);
    fullCycle("rd_after_ab", 1'b1, 1'b0, 1'b0, 1'b0);

    // Aborted write with counter still at 1 goes through RECOVER.
    pulseUnlock();
    startCycle(1'b0, 1'b0, 1'b0, 1'b1);
    firstEdge("ab_wr");
    idleBus();
    tick();
    check("ab_wr_rel", {6'd0, FLASH_WR_n}, 8'h03);
    check("ab_wr_dtack", {7'd0, DTACK_n}, 8'd1);
    startCycle(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("ab_wr_recover", {6'd0, FLASH_RD_n}, 8'h03);
    check("ab_wr_dtack2", {7'd0, DTACK_n}, 8'd1);
    firstEdge("rd_after_abwr");
    waitAck("rd_after_abwr");
    releaseCycle("rd_after_abwr");

    // Asynchronous reset during the ACK of a write.
    pulseUnlock();
    startCycle(1'b0, 1'b1, 1'b0, 1'b1);
    firstEdge("rst_wr_cyc");
    waitAck("rst_wr_cyc");
    #2 RESET_n = 1'b0;
    #1;
    check("rst_ack_wr", {6'd0, FLASH_WR_n}, 8'h03);
    check("rst_ack_dtack", {7'd0, DTACK_n}, 8'd1);
    idleBus();
    tbUnlocked = 1'b0;
    #3 RESET_n = 1'b1;
    tick();
    fullCycle("rd_after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Unlock sequencing; the model decides whether the lock is in effect.
    fullCycle("lk_wr_locked", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    pulseUnlock();
    fullCycle("lk_wr_unlocked", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    fullCycle("lk_rd", 1'b1, 1'b0, 1'b0, 1'b0);
    fullCycle("lk_wr_relocked", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
